// File: rtl/mmio_dma_pkg.sv
// mmio_dma_pkg
// Shared definitions for the MMIO word-copy DMA master: the controller state
// encoding, default stride/timeout values, and the base addresses of the
// crypto peripheral windows and the RAM window for benches and software.
package mmio_dma_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    WR_REQ,
    WR_WAIT,
    FIN
  } dma_state_e;

  localparam int DEFAULT_ADDR_STRIDE    = 4;
  localparam int DEFAULT_TIMEOUT_CYCLES = 16;

  localparam logic [31:0] AES_BASE     = 32'h4000_0000;
  localparam logic [31:0] RSA_BASE     = 32'h4000_1000;
  localparam logic [31:0] ED25519_BASE = 32'h4000_2000;
  localparam logic [31:0] BIKE_BASE    = 32'h4000_3000;
  localparam logic [31:0] RAM_BASE     = 32'h4000_4000;

endpackage

// File: rtl/mmio_dma_master_if.sv
// mmio_dma_master_if
// Crypto peripheral MMIO bus: addr/wdata/we/valid from the master,
// rdata/ready back from the slave. ready is registered by slaves, so it
// never arrives in the same cycle as the valid it answers.
//   master modport: drives addr, wdata, we, valid; samples rdata, ready
//   slave  modport: the reverse
interface mmio_dma_master_if;

  logic [31:0] addr;
  logic [31:0] wdata;
  logic        we;
  logic        valid;
  logic [31:0] rdata;
  logic        ready;

  modport master (
    output addr, wdata, we, valid,
    input  rdata, ready
  );

  modport slave (
    input  addr, wdata, we, valid,
    output rdata, ready
  );

endinterface

// File: rtl/bus_timeout_ctr.sv
// bus_timeout_ctr
// Loadable, clearable down-counter for bounding bus wait states. Load it in
// the request cycle with (limit - 1); while en is high it counts down and
// stops at zero. expired is high whenever the count is zero.
//   clk, rst    clock, synchronous active-high reset
//   load        load load_val (lower priority than clear)
//   clear       force the count to zero
//   en          count down one step this cycle
//   load_val    value to load
//   expired     count == 0
module bus_timeout_ctr #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         clear,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         expired
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/mmio_dma_master.sv
// mmio_dma_master
// Single-channel word-copy DMA engine mastering the crypto MMIO bus. Copies
// len_words 32-bit words from src to dst, one read then one write per word,
// with independently incrementing or fixed addresses and a per-access
// wait-state timeout.
//   clk, rst                   clock, synchronous active-high reset
//   start                      begin a transfer (ignored while busy)
//   src_addr, dst_addr         first addresses, sampled on accepted start
//   len_words                  word count, sampled on accepted start
//   src_inc, dst_inc           advance the address by ADDR_STRIDE per word
//   busy, done, err            status; err is sticky until the next start
//   words_done                 words fully written in current/last transfer
//   bus                        MMIO master port
module mmio_dma_master
  import mmio_dma_pkg::*;
#(
  parameter int ADDR_STRIDE    = DEFAULT_ADDR_STRIDE,
  parameter int LEN_W          = 16,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [31:0]       src_addr,
  input  logic [31:0]       dst_addr,
  input  logic [LEN_W-1:0]  len_words,
  input  logic              src_inc,
  input  logic              dst_inc,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [LEN_W-1:0]  words_done,
  mmio_dma_master_if.master bus
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  dma_state_e       state, next_state;
  logic [31:0]      src_q, dst_q, data_buf;
  logic [LEN_W-1:0] remaining;
  logic             zero_pend;
  logic             accept;
  logic             in_wait;
  logic             to_expired;

  // A start is taken in IDLE or in the FIN cycle, where busy has already
  // fallen; zero_pend also counts as busy.
  assign accept  = start && (((state == IDLE) && !zero_pend) || (state == FIN));
  assign in_wait = (state == RD_WAIT) || (state == WR_WAIT);

  // The counter is armed in each request cycle so the following wait state
  // gets exactly TIMEOUT_CYCLES cycles before expiring.
  bus_timeout_ctr #(.W(TO_W)) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .load     ((state == RD_REQ) || (state == WR_REQ)),
    .clear    ((state == IDLE) || ((state == RD_WAIT) && bus.ready)),
    .en       (in_wait && !bus.ready),
    .load_val (TO_W'(TIMEOUT_CYCLES - 1)),
    .expired  (to_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // A zero-length request parks in IDLE for one cycle (zero_pend) before
  // FIN, so its done lands on the same second cycle a real transfer's
  // bookkeeping would need.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: begin
        if (zero_pend) begin
          next_state = FIN;
        end else if (accept) begin
          next_state = (len_words == '0) ? IDLE : RD_REQ;
        end
      end
      RD_REQ:  next_state = RD_WAIT;
      RD_WAIT: begin
        if (bus.ready) begin
          next_state = WR_REQ;
        end else if (to_expired) begin
          next_state = FIN;
        end
      end
      WR_REQ:  next_state = WR_WAIT;
      WR_WAIT: begin
        if (bus.ready) begin
          next_state = (remaining == LEN_W'(1)) ? FIN : RD_REQ;
        end else if (to_expired) begin
          next_state = FIN;
        end
      end
      FIN: begin
        if (accept) begin
          next_state = (len_words == '0) ? IDLE : RD_REQ;
        end else begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // valid is a single-cycle strobe per access because slaves re-execute on
  // every cycle they see it; addr/we stay held through the wait state.
  always_comb begin
    busy      = ((state != IDLE) && (state != FIN)) || zero_pend;
    done      = (state == FIN);
    bus.valid = (state == RD_REQ) || (state == WR_REQ);
    bus.we    = (state == WR_REQ) || (state == WR_WAIT);
    bus.addr  = 32'h0;
    bus.wdata = 32'h0;
    if ((state == RD_REQ) || (state == RD_WAIT)) begin
      bus.addr = src_q;
    end else if ((state == WR_REQ) || (state == WR_WAIT)) begin
      bus.addr  = dst_q;
      bus.wdata = data_buf;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      src_q      <= '0;
      dst_q      <= '0;
      data_buf   <= '0;
      remaining  <= '0;
      words_done <= '0;
      err        <= 1'b0;
      zero_pend  <= 1'b0;
    end else begin
      zero_pend <= accept && (len_words == '0);
      if (accept) begin
        src_q      <= src_addr;
        dst_q      <= dst_addr;
        remaining  <= len_words;
        words_done <= '0;
        err        <= 1'b0;
      end
      if ((state == RD_WAIT) && bus.ready) begin
        data_buf <= bus.rdata;
      end
      // Address wrap-around past 0xFFFF_FFFF is deliberately not flagged.
      if ((state == WR_WAIT) && bus.ready) begin
        words_done <= words_done + 1'b1;
        remaining  <= remaining - 1'b1;
        src_q      <= src_q + (src_inc ? 32'(ADDR_STRIDE) : 32'd0);
        dst_q      <= dst_q + (dst_inc ? 32'(ADDR_STRIDE) : 32'd0);
      end
      if (in_wait && !bus.ready && to_expired) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mmio_dma_master.sv
// tb_mmio_dma_master
// Directed bench for mmio_dma_master. A registered slave model answers each
// valid one cycle later with rdata = addr + 0x1000_0000; it can be muted
// (unmapped region) or made to raise a stale ready during request cycles.
// Every bus access and done pulse is logged on the falling edge together
// with the cycle number, and the directed steps compare the log against
// hand-computed values.
module tb_mmio_dma_master;
  import mmio_dma_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] src_addr = '0;
  logic [31:0] dst_addr = '0;
  logic [15:0] len_words = '0;
  logic        src_inc = 1'b0;
  logic        dst_inc = 1'b0;
  logic        busy, done, err;
  logic [15:0] words_done;

  mmio_dma_master_if bus ();

  mmio_dma_master #(
    .ADDR_STRIDE    (4),
    .LEN_W          (16),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .src_addr   (src_addr),
    .dst_addr   (dst_addr),
    .len_words  (len_words),
    .src_inc    (src_inc),
    .dst_inc    (dst_inc),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .words_done (words_done),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  // Slave model.
  logic        slave_en = 1'b1;
  logic        stale_en = 1'b0;
  logic        ready_q = 1'b0;
  logic [31:0] rdata_q = '0;

  always @(posedge clk) begin
    ready_q <= slave_en & bus.valid;
    rdata_q <= bus.addr + 32'h1000_0000;
  end

  assign bus.ready = ready_q | (stale_en & bus.valid);
  assign bus.rdata = rdata_q;

  // Cycle counter and falling-edge monitor.
  int          cyc = 0;
  logic        log_we[$];
  logic [31:0] log_addr[$];
  logic [31:0] log_wdata[$];
  int          log_cyc[$];
  int          done_cnt = 0;
  int          done_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.valid) begin
      log_we.push_back(bus.we);
      log_addr.push_back(bus.addr);
      log_wdata.push_back(bus.wdata);
      log_cyc.push_back(cyc);
    end
    if (done) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
  end

  int compared = 0;
  int mismatched = 0;
  int log_base = 0;
  int done_base = 0;
  int t0 = 0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Presents a one-cycle start; returns at the falling edge of the first
  // cycle after the accepting edge (relative cycle 1).
  task automatic applyStimulus(input logic [31:0] s, input logic [31:0] d,
                               input logic [15:0] n, input logic si, input logic di);
    @(negedge clk);
    log_base  = log_addr.size();
    done_base = done_cnt;
    src_addr  = s;
    dst_addr  = d;
    len_words = n;
    src_inc   = si;
    dst_inc   = di;
    start     = 1'b1;
    t0        = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  function automatic int numAccesses(input logic w);
    int n = 0;
    for (int i = log_base; i < log_addr.size(); i++) begin
      if (log_we[i] == w) n++;
    end
    return n;
  endfunction

  function automatic logic [31:0] nthAddr(input logic w, input int k);
    int n = 0;
    for (int i = log_base; i < log_addr.size(); i++) begin
      if (log_we[i] == w) begin
        if (n == k) return log_addr[i];
        n++;
      end
    end
    return 32'hDEAD_DEAD;
  endfunction

  function automatic logic [31:0] nthData(input int k);
    int n = 0;
    for (int i = log_base; i < log_addr.size(); i++) begin
      if (log_we[i]) begin
        if (n == k) return log_wdata[i];
        n++;
      end
    end
    return 32'hDEAD_DEAD;
  endfunction

  function automatic int firstValidRel();
    if (log_cyc.size() > log_base) return log_cyc[log_base] - t0;
    return -1;
  endfunction

  initial begin
    $display("[TB] start");

    // Reset state.
    repeat (3) @(negedge clk);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_err", 32'(err), 32'd0);
    checkOutput("rst_words_done", 32'(words_done), 32'd0);
    checkOutput("rst_valid", 32'(bus.valid), 32'd0);
    checkOutput("rst_we", 32'(bus.we), 32'd0);
    checkOutput("rst_addr", bus.addr, 32'd0);
    checkOutput("rst_wdata", bus.wdata, 32'd0);
    rst = 1'b0;

    // RAM to RAM, 4 words, both incrementing.
    applyStimulus(RAM_BASE, RAM_BASE + 32'h40, 16'd4, 1'b1, 1'b1);
    repeat (30) @(negedge clk);
    checkOutput("t1_reads", 32'(numAccesses(1'b0)), 32'd4);
    checkOutput("t1_writes", 32'(numAccesses(1'b1)), 32'd4);
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("t1_rd_addr%0d", k), nthAddr(1'b0, k), 32'h4000_4000 + 32'(4 * k));
      checkOutput($sformatf("t1_wr_addr%0d", k), nthAddr(1'b1, k), 32'h4000_4040 + 32'(4 * k));
      checkOutput($sformatf("t1_wr_data%0d", k), nthData(k), 32'h5000_4000 + 32'(4 * k));
    end
    checkOutput("t1_first_valid_rel", 32'(firstValidRel()), 32'd1);
    checkOutput("t1_words_done", 32'(words_done), 32'd4);
    checkOutput("t1_err", 32'(err), 32'd0);
    checkOutput("t1_done_count", 32'(done_cnt - done_base), 32'd1);
    checkOutput("t1_done_rel", 32'(done_cyc - t0), 32'd17);

    // Fixed destination, 3 words.
    applyStimulus(RAM_BASE, AES_BASE + 32'h10, 16'd3, 1'b1, 1'b0);
    repeat (25) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      checkOutput($sformatf("t2_wr_addr%0d", k), nthAddr(1'b1, k), 32'h4000_0010);
      checkOutput($sformatf("t2_wr_data%0d", k), nthData(k), 32'h5000_4000 + 32'(4 * k));
    end
    checkOutput("t2_words_done", 32'(words_done), 32'd3);
    checkOutput("t2_done_rel", 32'(done_cyc - t0), 32'd13);

    // Zero-length transfer.
    applyStimulus(AES_BASE, RAM_BASE, 16'd0, 1'b1, 1'b1);
    checkOutput("t3_busy_rel1", 32'(busy), 32'd1);
    repeat (5) @(negedge clk);
    checkOutput("t3_accesses", 32'(log_addr.size() - log_base), 32'd0);
    checkOutput("t3_done_count", 32'(done_cnt - done_base), 32'd1);
    checkOutput("t3_done_rel", 32'(done_cyc - t0), 32'd2);
    checkOutput("t3_words_done", 32'(words_done), 32'd0);
    checkOutput("t3_busy_after", 32'(busy), 32'd0);

    // Unmapped source: no ready ever.
    slave_en = 1'b0;
    applyStimulus(32'h4000_5000, RAM_BASE, 16'd2, 1'b1, 1'b1);
    repeat (30) @(negedge clk);
    checkOutput("t4_reads", 32'(numAccesses(1'b0)), 32'd1);
    checkOutput("t4_writes", 32'(numAccesses(1'b1)), 32'd0);
    checkOutput("t4_err", 32'(err), 32'd1);
    checkOutput("t4_words_done", 32'(words_done), 32'd0);
    checkOutput("t4_done_count", 32'(done_cnt - done_base), 32'd1);
    checkOutput("t4_done_rel", 32'(done_cyc - t0), 32'd18);
    slave_en = 1'b1;

    // Second start while busy, then reset inside the second WR_WAIT.
    applyStimulus(RAM_BASE, RAM_BASE + 32'h40, 16'd4, 1'b1, 1'b1);
    checkOutput("t5_err_cleared", 32'(err), 32'd0);
    src_addr  = AES_BASE;
    len_words = 16'd1;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    checkOutput("t5_words_done_rel8", 32'(words_done), 32'd1);
    checkOutput("t5_we_rel8", 32'(bus.we), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("t5_accesses", 32'(log_addr.size() - log_base), 32'd4);
    checkOutput("t5_rd_addr1", nthAddr(1'b0, 1), 32'h4000_4004);
    checkOutput("t5_state", 32'(dut.state), 32'(IDLE));
    checkOutput("t5_busy", 32'(busy), 32'd0);
    checkOutput("t5_words_done", 32'(words_done), 32'd0);
    checkOutput("t5_valid", 32'(bus.valid), 32'd0);
    checkOutput("t5_we", 32'(bus.we), 32'd0);
    checkOutput("t5_addr", bus.addr, 32'd0);
    checkOutput("t5_wdata", bus.wdata, 32'd0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    checkOutput("t5_no_traffic", 32'(log_addr.size() - log_base), 32'd4);
    checkOutput("t5_no_done", 32'(done_cnt - done_base), 32'd0);

    // Stale ready raised during every request cycle.
    stale_en = 1'b1;
    applyStimulus(RAM_BASE, RAM_BASE + 32'h80, 16'd2, 1'b1, 1'b1);
    repeat (15) @(negedge clk);
    checkOutput("t6_reads", 32'(numAccesses(1'b0)), 32'd2);
    checkOutput("t6_writes", 32'(numAccesses(1'b1)), 32'd2);
    checkOutput("t6_wr_data1", nthData(1), 32'h5000_4004);
    checkOutput("t6_wr_addr1", nthAddr(1'b1, 1), 32'h4000_4084);
    checkOutput("t6_words_done", 32'(words_done), 32'd2);
    checkOutput("t6_err", 32'(err), 32'd0);
    checkOutput("t6_done_rel", 32'(done_cyc - t0), 32'd9);
    stale_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mmio_dma_master.md
# mmio_dma_master

Single-channel word-copy DMA engine that masters the crypto peripheral MMIO bus (addr/wdata/we/valid → rdata/ready) directly upstream of the crypto peripheral top. It moves `len_words` 32-bit words from a source region to a destination region. Typical transfers are:

- RAM window (0x4000_4000) to an AES/RSA/Ed25519/BIKE data register.
- Result registers back to RAM.

Each address can independently increment or stay fixed, so one peripheral FIFO register can be streamed. A per-access timeout flags transfers to unmapped addresses.

## Interface
Parameters:
- `ADDR_STRIDE`, 4: address increment per word when the corresponding `*_inc` bit is set.
- `LEN_W`, 16: width of the length and progress counters.
- `TIMEOUT_CYCLES`, 16: maximum wait-state cycles per access before an error is declared.

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `start`  in  1  one-cycle request to begin a transfer; ignored while `busy`.
- `src_addr`  in  32  first source address, sampled on accepted `start`.
- `dst_addr`  in  32  first destination address, sampled on accepted `start`.
- `len_words`  in  LEN_W  number of words to copy, sampled on accepted `start`.
- `src_inc`  in  1  1 = source address advances by ADDR_STRIDE; 0 = fixed.
- `dst_inc`  in  1  same as `src_inc`, for the destination.
- `busy`  out  1  high from the cycle after accepted `start` until `done`.
- `done`  out  1  one-cycle pulse at the end of a transfer (normal or error).
- `err`  out  1  sticky timeout flag; cleared by the next accepted `start`.
- `words_done`  out  LEN_W  count of words fully written in the current or last transfer.
- `addr`  out  32  bus address.
- `wdata`  out  32  bus write data.
- `we`  out  1  bus write enable.
- `valid`  out  1  bus request strobe.
- `rdata`  in  32  bus read data; meaningful only while `ready` is high.
- `ready`  in  1  bus acknowledge; slaves register it, so it arrives no earlier than one cycle after `valid`.

## Operation
- States: `IDLE`, `RD_REQ`, `RD_WAIT`, `WR_REQ`, `WR_WAIT`, `FIN`.
- `IDLE`:
  - `start`=1 latches `src_addr`, `dst_addr` and `len_words`, and clears `err` and `words_done`.
  - If `len_words`=0, go to `FIN` with no bus traffic; otherwise go to `RD_REQ`.
- `RD_REQ`: drive `valid`=1, `we`=0, `addr`=src for exactly one cycle, then go to `RD_WAIT`.
- `RD_WAIT`:
  - `valid`=0; `addr` and `we` stay held.
  - On `ready`=1, capture `rdata` into the data buffer, clear the timeout counter and go to `WR_REQ`.
  - Otherwise increment the timeout counter.
- `WR_REQ`: drive `valid`=1, `we`=1, `addr`=dst, `wdata`=buffer for one cycle, then go to `WR_WAIT`.
- `WR_WAIT`:
  - On `ready`=1: increment `words_done`, advance src/dst (only where `*_inc`=1; 32-bit wrap-around is allowed and not flagged), and decrement the remaining count.
  - Then go to `FIN` if the remaining count reaches 0, else go to `RD_REQ`.
- Timeout: in either WAIT state, if `TIMEOUT_CYCLES` cycles pass with `ready`=0, set `err`=1 and go to `FIN`. The failing word is not counted.
- `FIN`: `done`=1 for one cycle, then go to `IDLE`.
- `valid` is a one-cycle pulse per access by design. The slaves re-execute on every cycle they see `valid`, so holding it would duplicate accesses.
- `ready` seen in any state other than `RD_WAIT`/`WR_WAIT` is ignored.
- `start` while `busy`: ignored; latched parameters are unchanged.
- `rst` at any time: go to `IDLE` and drop `valid` in the same edge. No partial access is retried.

## Timing
- Reset values: `busy`=0, `done`=0, `err`=0, `words_done`=0, `valid`=0, `we`=0, `addr`=0, `wdata`=0.
- Cycle-level sequence from `start` sampled high at edge E0:
  - first `valid` is in the cycle after E0;
  - with zero-wait slaves (`ready` one cycle after `valid`), each word costs 4 cycles;
  - `done` is asserted the cycle after the final write `ready`.
- Total latency for N words, zero-wait: 4N+1 cycles from start to `done`.
- `len_words`=0: `done` is asserted in the second cycle after E0.
- `busy` falls in the same cycle `done` pulses, and a new `start` is accepted in that cycle.

## Structure
- Package `mmio_dma_pkg` holds:
  - the state enum;
  - the default `ADDR_STRIDE` and `TIMEOUT_CYCLES` constants;
  - the RAM base and crypto base addresses (0x4000_0000, 0x4000_1000, 0x4000_2000, 0x4000_3000, 0x4000_4000) for benches and software.
- Sub-module `bus_timeout_ctr`: a loadable, clearable down-counter with an `expired` output, reusable by other bus masters.

## Test plan
- RAM→RAM copy: `src`=0x4000_4000, `dst`=0x4000_4040, `len`=4, both increment → 4 reads and 4 writes with correct addresses; `words_done`=4, `done` once at cycle 17, `err`=0.
- Fixed destination: `len`=3, `dst_inc`=0, `dst`=0x4000_0010 → all three writes go to 0x4000_0010 in source order.
- `len_words`=0 → no `valid` ever asserted; `done` pulses in the second cycle after start.
- Unmapped source: slave model never asserts `ready` → `err`=1 and `done` exactly TIMEOUT_CYCLES+1 cycles after the `RD_REQ` cycle; `words_done`=0; no write issued.
- `start` pulsed mid-transfer, then `rst` asserted mid-`WR_WAIT` → the second start is ignored; after reset all outputs are 0, the state is `IDLE`, and there is no further bus traffic.
- Stale `ready` held high by the bench during `RD_REQ` → the engine still performs exactly one read per word, and the word count stays correct.
